// File: rtl/alu_pkg.sv
// Shared constants, opcode names and types for the ALU and its two-port arbiter.
package alu_pkg;
    localparam int WIDTH   = 32;
    localparam int OPW     = 4;
    localparam int NUM_OPS = 12;

    localparam logic [OPW-1:0] OP_ADD  = 4'd0;
    localparam logic [OPW-1:0] OP_SUB  = 4'd1;
    localparam logic [OPW-1:0] OP_AND  = 4'd2;
    localparam logic [OPW-1:0] OP_OR   = 4'd3;
    localparam logic [OPW-1:0] OP_XOR  = 4'd4;
    localparam logic [OPW-1:0] OP_SLL  = 4'd5;
    localparam logic [OPW-1:0] OP_SRL  = 4'd6;
    localparam logic [OPW-1:0] OP_SRA  = 4'd7;
    localparam logic [OPW-1:0] OP_INC  = 4'd8;
    localparam logic [OPW-1:0] OP_DEC  = 4'd9;
    localparam logic [OPW-1:0] OP_PASS = 4'd10;
    localparam logic [OPW-1:0] OP_SLTU = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;
endpackage

// File: rtl/alu.sv
// Combinational ALU: dr is the WIDTH-bit result, cf the carry/borrow/compare flag.
module alu #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int OPW   = alu_pkg::OPW
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] tr,
    input  logic [WIDTH-1:0] sr,
    output logic [WIDTH-1:0] dr,
    output logic             cf
);
    import alu_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] sh;
    logic [WIDTH:0] res;

    assign sh = sr[SHW-1:0];

    // res[WIDTH] is the flag: carry for add/inc, borrow for sub/dec
    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = {1'b0, tr} + {1'b0, sr};
            OP_SUB:  res = {1'b0, tr} - {1'b0, sr};
            OP_AND:  res = {1'b0, tr & sr};
            OP_OR:   res = {1'b0, tr | sr};
            OP_XOR:  res = {1'b0, tr ^ sr};
            OP_SLL:  res = {1'b0, tr << sh};
            OP_SRL:  res = {1'b0, tr >> sh};
            OP_SRA:  res = {1'b0, $unsigned($signed(tr) >>> sh)};
            OP_INC:  res = {1'b0, tr} + {{WIDTH{1'b0}}, 1'b1};
            OP_DEC:  res = {1'b0, tr} - {{WIDTH{1'b0}}, 1'b1};
            OP_PASS: res = {1'b0, sr};
            OP_SLTU: res = {tr < sr, {(WIDTH-1){1'b0}}, tr < sr};
            default: res = '0;
        endcase
    end

    assign dr = res[WIDTH-1:0];
    assign cf = res[WIDTH];
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between two valid/ready requesters.
module alu_arbiter #(
    parameter int WIDTH   = alu_pkg::WIDTH,
    parameter int OPW     = alu_pkg::OPW,
    parameter int NUM_OPS = alu_pkg::NUM_OPS,
    parameter int CNTW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_tr,
    input  logic [WIDTH-1:0] req0_sr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_tr,
    input  logic [WIDTH-1:0] req1_sr,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_dr,
    output logic             rsp0_cf,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_dr,
    output logic             rsp1_cf,
    output logic             rsp1_err,
    output logic             busy,
    output logic [CNTW-1:0]  op_count
);
    import alu_pkg::*;

    state_t           state_q, state_d;
    req_id_t          ptr_q, ptr_d;
    req_id_t          owner_q, owner_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] tr_q, tr_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dr_q, dr_d;
    logic             cf_q, cf_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] alu_dr;
    logic             alu_cf;
    req_id_t          win;
    logic             illegal;

    alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
        .op (op_q),
        .tr (tr_q),
        .sr (sr_q),
        .dr (alu_dr),
        .cf (alu_cf)
    );

    assign illegal = (int'(op_q) >= NUM_OPS);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        op_d       = op_q;
        tr_d       = tr_q;
        sr_d       = sr_q;
        dr_d       = dr_q;
        cf_d       = cf_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // Pointer only breaks ties; a lone requester always wins
        win = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        case (state_q)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    req0_ready = ~win;
                    req1_ready = win;
                    owner_d    = win;
                    op_d       = win ? req1_op : req0_op;
                    tr_d       = win ? req1_tr : req0_tr;
                    sr_d       = win ? req1_sr : req0_sr;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                err_d   = illegal;
                dr_d    = illegal ? '0 : alu_dr;
                cf_d    = illegal ? 1'b0 : alu_cf;
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    cnt_d   = cnt_q + CNTW'(1);
                    ptr_d   = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            op_q    <= '0;
            tr_q    <= '0;
            sr_q    <= '0;
            dr_q    <= '0;
            cf_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            tr_q    <= tr_d;
            sr_q    <= sr_d;
            dr_q    <= dr_d;
            cf_q    <= cf_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Both ports share the result registers; only the owner's valid is raised
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp0_dr    = dr_q;
    assign rsp1_dr    = dr_q;
    assign rsp0_cf    = cf_q;
    assign rsp1_cf    = cf_q;
    assign rsp0_err   = err_q;
    assign rsp1_err   = err_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: grants are predicted and results modelled arithmetically.
module tb_alu_arbiter;
    localparam int W    = 32;
    localparam int OPW  = 4;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req0_valid = 0, req1_valid = 0;
    logic            req0_ready, req1_ready;
    logic [OPW-1:0]  req0_op = '0, req1_op = '0;
    logic [W-1:0]    req0_tr = '0, req0_sr = '0, req1_tr = '0, req1_sr = '0;
    logic            rsp0_valid, rsp1_valid;
    logic            rsp0_ready = 1, rsp1_ready = 1;
    logic [W-1:0]    rsp0_dr, rsp1_dr;
    logic            rsp0_cf, rsp1_cf, rsp0_err, rsp1_err;
    logic            busy;
    logic [CNTW-1:0] op_count;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .OPW(OPW), .NUM_OPS(12), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_tr(req0_tr), .req0_sr(req0_sr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_tr(req1_tr), .req1_sr(req1_sr),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_dr(rsp0_dr),
        .rsp0_cf(rsp0_cf), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_dr(rsp1_dr),
        .rsp1_cf(rsp1_cf), .rsp1_err(rsp1_err),
        .busy(busy), .op_count(op_count)
    );

    typedef struct {
        bit         owner;
        logic [W-1:0] dr;
        bit         cf;
        bit         err;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    bit   grant_log[$];
    bit   idle_m = 1, ptr_m = 0, outst_m = 0;
    logic [CNTW-1:0] cnt_m = '0;
    int   cyc = 0, acc_cyc = 0;
    bit   rst_prev_low = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU written directly from the opcode definitions
    function automatic exp_t model(input bit owner, input logic [3:0] op,
                                   input logic [W-1:0] tr, input logic [W-1:0] sr);
        exp_t   e;
        longint a = tr;
        longint b = sr;
        longint s;
        int     sh = int'(sr[4:0]);
        e.owner = owner; e.dr = '0; e.cf = 0; e.err = 0;
        case (op)
            4'd0:  begin s = a + b; e.dr = tr + sr; e.cf = (s > 64'sd4294967295); end
            4'd1:  begin e.dr = tr - sr; e.cf = (tr < sr); end
            4'd2:  e.dr = tr & sr;
            4'd3:  e.dr = tr | sr;
            4'd4:  e.dr = tr ^ sr;
            4'd5:  e.dr = tr << sh;
            4'd6:  e.dr = tr >> sh;
            4'd7:  e.dr = $signed(tr) >>> sh;
            4'd8:  begin e.dr = tr + 1; e.cf = (tr == 32'hFFFF_FFFF); end
            4'd9:  begin e.dr = tr - 1; e.cf = (tr == 0); end
            4'd10: e.dr = sr;
            4'd11: begin e.cf = (tr < sr); e.dr = {31'b0, tr < sr}; end
            default: e.err = 1;
        endcase
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Grant prediction and expected-result push
    always @(negedge clk) begin : scoreboard
        bit exp0, exp1, who;
        if (!rst_n) begin
            chk("ready0_in_reset", req0_ready, 0);
            chk("ready1_in_reset", req1_ready, 0);
            if (rst_prev_low) begin
                chk("reset_busy", busy, 0);
                chk("reset_rsp0_valid", rsp0_valid, 0);
                chk("reset_rsp1_valid", rsp1_valid, 0);
                chk("reset_op_count", op_count, 0);
            end
            sb_q.delete();
            idle_m  <= 1;
            ptr_m   <= 0;
            cnt_m   <= '0;
            outst_m <= 0;
        end else begin
            exp0 = idle_m && req0_valid && (!req1_valid || !ptr_m);
            exp1 = idle_m && req1_valid && (!req0_valid || ptr_m);
            chk("req0_ready", req0_ready, exp0);
            chk("req1_ready", req1_ready, exp1);
            chk("busy", busy, !idle_m);
            chk("op_count", op_count, cnt_m);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                who = req1_valid && req1_ready;
                if (who) sb_q.push_back(model(1, req1_op, req1_tr, req1_sr));
                else     sb_q.push_back(model(0, req0_op, req0_tr, req0_sr));
                grant_log.push_back(who);
                idle_m  <= 0;
                outst_m <= 1;
                acc_cyc <= cyc;
            end
        end
        rst_prev_low = !rst_n;
    end

    // Response monitor: pops and compares whenever a result is presented
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   who;
        int   d;
        if (rst_n) begin
            d = cyc - acc_cyc;
            if (outst_m && d == 1)
                chk("latency_exec_no_rsp", rsp0_valid | rsp1_valid, 0);
            if (outst_m && d == 2 && sb_q.size() > 0)
                chk("latency_rsp_valid", sb_q[0].owner ? rsp1_valid : rsp0_valid, 1);
            if (rsp0_valid || rsp1_valid) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got rsp0_valid=%0d rsp1_valid=%0d expected none",
                             rsp0_valid, rsp1_valid);
                end else begin
                    e   = sb_q[0];
                    who = rsp1_valid;
                    chk("rsp_both_valid", rsp0_valid & rsp1_valid, 0);
                    chk("rsp_owner", who, e.owner);
                    chk("rsp_dr", who ? rsp1_dr : rsp0_dr, e.dr);
                    chk("rsp_cf", who ? rsp1_cf : rsp0_cf, e.cf);
                    chk("rsp_err", who ? rsp1_err : rsp0_err, e.err);
                    if (who ? rsp1_ready : rsp0_ready) begin
                        $display("rsp r%0d dr=%08h cf=%0d err=%0d count_before=%0d",
                                 who, e.dr, e.cf, e.err, cnt_m);
                        void'(sb_q.pop_front());
                        cnt_m   <= cnt_m + 1'b1;
                        ptr_m   <= ~who;
                        idle_m  <= 1;
                        outst_m <= 0;
                    end
                end
            end
        end
    end

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive_req(input bit r, input bit v, input logic [3:0] op,
                             input logic [W-1:0] tr, input logic [W-1:0] sr);
        if (r) begin req1_valid = v; req1_op = op; req1_tr = tr; req1_sr = sr; end
        else   begin req0_valid = v; req0_op = op; req0_tr = tr; req0_sr = sr; end
    endtask

    task automatic wait_hs(input bit r);
        bit hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            hit = r ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: requester %0d got no ready, required within 30 cycles", r);
        end
        @(posedge clk); #1;
        if (r) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = !busy && (sb_q.size() == 0) && !req0_valid && !req1_valid;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d, required idle within 60 cycles",
                     busy, sb_q.size());
        end
    endtask

    task automatic single(input bit r, input logic [3:0] op, input logic [W-1:0] tr,
                          input logic [W-1:0] sr);
        @(posedge clk); #1;
        drive_req(r, 1, op, tr, sr);
        wait_hs(r);
        wait_idle();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst_n = 0; req0_valid = 0; req1_valid = 0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic rand_traffic(input int n_ops, input int pv, input int pr, input int fix_op);
        int granted = 0;
        int budget  = n_ops * 60;
        bit h0 = 0, h1 = 0;
        while (granted < n_ops && budget > 0) begin
            @(posedge clk); #1;
            if (h0 || !req0_valid) begin
                if ($urandom_range(0, 99) < pv)
                    drive_req(0, 1, (fix_op < 0) ? 4'($urandom_range(0, 15)) : 4'(fix_op),
                              rand_word(), rand_word());
                else req0_valid = 0;
            end
            if (h1 || !req1_valid) begin
                if ($urandom_range(0, 99) < pv)
                    drive_req(1, 1, (fix_op < 0) ? 4'($urandom_range(0, 15)) : 4'(fix_op),
                              rand_word(), rand_word());
                else req1_valid = 0;
            end
            rsp0_ready = ($urandom_range(0, 99) < pr);
            rsp1_ready = ($urandom_range(0, 99) < pr);
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            granted += int'(h0) + int'(h1);
            budget--;
        end
        if (granted < n_ops) begin
            checks++; errors++;
            $display("FAIL traffic_timeout: got %0d grants, required %0d", granted, n_ops);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Single request after reset
        single(0, 4'd0, 32'd32, 32'd21);
        chk("single_op_count", op_count, 1);

        // Simultaneous requests right after reset alternate starting with requester 0
        do_reset(2);
        grant_log.delete();
        rand_traffic(6, 100, 100, 1);
        chk("alt_grants", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("alt_grant_%0d", i), grant_log[i], i % 2);

        // Backpressure on requester 1 while requester 0 waits
        @(posedge clk); #1;
        rsp1_ready = 0; rsp0_ready = 1;
        drive_req(1, 1, 4'd0, rand_word(), rand_word());
        wait_hs(1);
        drive_req(0, 1, 4'd1, rand_word(), rand_word());
        for (int i = 0; i < 10 && !rsp1_valid; i++) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp1_valid", rsp1_valid, 1);
            chk("bp_busy", busy, 1);
            chk("bp_req0_ready", req0_ready, 0);
        end
        @(posedge clk); #1 rsp1_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_idle", busy, 0);
        wait_hs(0);
        wait_idle();

        // Illegal opcode
        single(0, 4'b1100, 32'd7, 32'd3);

        // Reset during EXEC, with the pointer left at 1 beforehand
        single(0, 4'd2, rand_word(), rand_word());
        @(posedge clk); #1;
        drive_req(1, 1, 4'd0, rand_word(), rand_word());
        wait_hs(1);
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        grant_log.delete();
        rand_traffic(2, 100, 100, 3);
        chk("post_reset_first_grant", grant_log.size() > 0 ? grant_log[0] : 1'b1, 0);
        single(1, 4'd8, 32'hFFFF_FFFF, 32'd0);

        // Random mixed traffic with backpressure
        rand_traffic(60, 60, 70, -1);

        // Counter wrap with a 4-bit counter
        do_reset(2);
        repeat (17) single(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)),
                           rand_word(), rand_word());
        chk("count_wrap", op_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
